// File: rtl/grostl_sub_bytes_fold_m.sv
`default_nettype none
// ============================================================================
// Module      : grostl_sub_bytes_fold_m
// Description : Masked Grostl SubBytes engine folded over time. A captured
//               NBYTES-byte masked state is pushed through NSBOX masked S-box
//               lanes, one NSBOX-byte chunk per cycle, with valid/ready
//               handshakes on the input and output sides.
// Revision    : 1.0 - initial release
// ============================================================================
module grostl_sub_bytes_fold_m #(
  parameter int NBYTES = 64,
  parameter int NSBOX  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [0:NBYTES-1][7:0] din,
  input  logic [0:NBYTES-1][7:0] imask,
  input  logic [0:NBYTES-1][7:0] omask,
  input  logic                   mask_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [0:NBYTES-1][7:0] dout,
  output logic                   busy
);

  localparam int NCHUNK = NBYTES / NSBOX;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  generate
    if (NBYTES % NSBOX != 0) begin : g_bad_fold
      $error("grostl_sub_bytes_fold_m: NBYTES must be a multiple of NSBOX");
    end
  endgenerate

  // GF(2^8) helpers over the AES polynomial x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // Forward S-box: inverse as x^254 (product of x^2 .. x^128), then affine map
  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  logic [1:0]             state;
  logic [1:0]             state_nx;
  logic [CW-1:0]          cnt;
  logic [0:NBYTES-1][7:0] din_q;
  logic [0:NBYTES-1][7:0] imask_q;
  logic [0:NBYTES-1][7:0] omask_q;
  logic                   accept;
  logic [IW-1:0]          chunk_base;

  logic [NSBOX-1:0][7:0]  sb_x;
  logic [NSBOX-1:0][7:0]  sb_mi;
  logic [NSBOX-1:0][7:0]  sb_mo;
  logic [NSBOX-1:0][7:0]  sb_y;

  assign accept     = in_valid && in_ready;
  assign chunk_base = IW'(int'(cnt) * NSBOX);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic: a DONE handshake may immediately start the next state
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (in_valid) state_nx = ST_BUSY;
      ST_BUSY: if (cnt == LAST_CHUNK) state_nx = ST_DONE;
      ST_DONE: if (out_ready) state_nx = in_valid ? ST_BUSY : ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state
  always_comb begin
    in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    out_valid = (state == ST_DONE);
    busy      = (state == ST_BUSY);
  end

  // Steer the active chunk onto the S-box lanes; lanes see zero outside BUSY
  always_comb begin
    sb_x  = '0;
    sb_mi = '0;
    sb_mo = '0;
    if (state == ST_BUSY) begin
      for (int j = 0; j < NSBOX; j++) begin
        sb_x[j]  = din_q[chunk_base + IW'(j)];
        sb_mi[j] = imask_q[chunk_base + IW'(j)];
        sb_mo[j] = omask_q[chunk_base + IW'(j)];
      end
    end
  end

  // Masked S-box lanes: S(x^m) re-masked with the output mask; the unmasked
  // value exists only inside this combinational path, never in a register
  genvar gl;
  generate
    for (gl = 0; gl < NSBOX; gl++) begin : g_lane
      assign sb_y[gl] = fwd_sbox(sb_x[gl] ^ sb_mi[gl]) ^ sb_mo[gl];
    end
  endgenerate

  // Capture the masked state at accept; masks are zeroed when masking is off
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_q   <= '0;
      imask_q <= '0;
      omask_q <= '0;
    end else if (accept) begin
      din_q   <= din;
      imask_q <= imask & {(NBYTES*8){mask_en}};
      omask_q <= omask & {(NBYTES*8){mask_en}};
    end
  end

  // Chunk counter: restarts at accept, wraps only on the BUSY -> DONE step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (accept)           cnt <= '0;
    else if (state == ST_BUSY) cnt <= (cnt == LAST_CHUNK) ? '0 : cnt + CW'(1);
  end

  // Write only the active chunk of dout; other bytes hold their value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
    end else if (state == ST_BUSY) begin
      for (int j = 0; j < NSBOX; j++) begin
        dout[chunk_base + IW'(j)] <= sb_y[j];
      end
    end
  end

endmodule
`default_nettype wire
